// File: rtl/sap3_pkg.sv
// Shared opcode, sub-op and state encodings for the SAP-3 accumulator core.
package sap3_pkg;

  // Memory-reference opcodes, held in the top nibble of the instruction
  localparam logic [3:0] OP_LDA  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_STA  = 4'h3;
  localparam logic [3:0] OP_LDB  = 4'h4;
  localparam logic [3:0] OP_CALL = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_JAC  = 4'h7;
  localparam logic [3:0] OP_JAZ  = 4'h8;
  localparam logic [3:0] OP_JAN  = 4'h9;
  localparam logic [3:0] OP_GRP  = 4'hF;

  // Register-only operations, selected by the second nibble when op is OP_GRP
  localparam logic [3:0] SUB_RET = 4'h0;
  localparam logic [3:0] SUB_AND = 4'h8;
  localparam logic [3:0] SUB_OR  = 4'h9;
  localparam logic [3:0] SUB_XOR = 4'hA;
  localparam logic [3:0] SUB_NOT = 4'hB;
  localparam logic [3:0] SUB_INC = 4'hC;
  localparam logic [3:0] SUB_INP = 4'hD;
  localparam logic [3:0] SUB_OUT = 4'hE;
  localparam logic [3:0] SUB_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/sap3_stack.sv
// Hardware return-address stack for CALL/RET. sp counts stored entries;
// the caller checks full/empty before pushing or popping, and the stack
// also ignores a push when full or a pop when empty.
module sap3_stack #(
  parameter int AW          = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [AW-1:0]  entries [2**IW];
  logic [SPW-1:0] sp_q;
  logic [SPW-1:0] sp_dec;

  assign sp_dec = sp_q - SPW'(1);
  assign full   = (sp_q == SPW'(STACK_DEPTH));
  assign empty  = (sp_q == '0);
  assign top    = entries[sp_dec[IW-1:0]];

  // Stack pointer: cleared by clr, moves by one on a legal push or pop
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      sp_q <= '0;
    end else if (push && !full) begin
      sp_q <= sp_q + SPW'(1);
    end else if (pop && !empty) begin
      sp_q <= sp_dec;
    end
  end

  // Entry storage: written on push only
  // NOTE: storage arrays take no reset; sp alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !full && !clr) begin
      entries[sp_q[IW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/sap3_core.sv
// SAP-3 accumulator CPU: internal RAM loaded through the prog port, a
// two-cycle FETCH/EXEC sequencer, A/B registers, carry flag, output
// register and a return stack for CALL/RET. Stack misuse halts with err.
module sap3_core
  import sap3_pkg::*;
#(
  parameter int DW          = 12,
  parameter int AW          = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          prog,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] d,
  input  logic [DW-1:0] i,
  output logic [DW-1:0] out,
  output logic          halted,
  output logic          err
);

  logic [DW-1:0] mem [2**AW];

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] b_q, b_d;
  logic          carry_q, carry_d;
  logic [DW-1:0] out_q, out_d;
  logic          err_q, err_d;

  logic          push, pop, sta_we;
  logic [AW-1:0] stack_top;
  logic          stack_full, stack_empty;

  logic [3:0]    op, sub;
  logic [AW-1:0] addr;
  logic [DW-1:0] fetch_word, m;
  logic          zero, neg;

  assign op         = ir_q[DW-1:DW-4];
  assign sub        = ir_q[DW-5:DW-8];
  assign addr       = ir_q[AW-1:0];
  assign fetch_word = mem[pc_q];
  assign m          = mem[addr];
  assign zero       = (acc_q == '0);
  assign neg        = acc_q[DW-1];

  assign out    = out_q;
  assign halted = (state_q == ST_HALT);
  assign err    = err_q;

  sap3_stack #(
    .AW          (AW),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .clr       (clr),
    .push      (push),
    .pop       (pop),
    .push_data (pc_q),
    .top       (stack_top),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  // RAM write port: programming port has priority over STA
  always_ff @(posedge clk) begin
    if (prog) begin
      mem[a] <= d;
    end else if (sta_we && !clr) begin
      mem[addr] <= acc_q;
    end
  end

  // Next-state, datapath and stack control for FETCH/EXEC/HALT
  // NOTE: every output gets a hold/idle default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    b_d     = b_q;
    carry_d = carry_q;
    out_d   = out_q;
    err_d   = err_q;
    push    = 1'b0;
    pop     = 1'b0;
    sta_we  = 1'b0;

    if (prog) begin
      pc_d    = '0;
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          ir_d    = fetch_word;
          pc_d    = pc_q + AW'(1);
          state_d = ST_EXEC;
        end
        ST_EXEC: begin
          state_d = ST_FETCH;
          case (op)
            OP_LDA: acc_d = m;
            OP_ADD: {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, m};
            OP_SUB: begin
              acc_d   = acc_q - m;
              carry_d = (acc_q < m);
            end
            OP_STA: sta_we = 1'b1;
            OP_LDB: b_d = m;
            OP_CALL: begin
              if (stack_full) begin
                err_d   = 1'b1;
                state_d = ST_HALT;
              end else begin
                push = 1'b1;
                pc_d = addr;
              end
            end
            OP_JMP: pc_d = addr;
            OP_JAC: if (carry_q) pc_d = addr;
            OP_JAZ: if (zero) pc_d = addr;
            OP_JAN: if (neg) pc_d = addr;
            OP_GRP: begin
              case (sub)
                SUB_RET: begin
                  if (stack_empty) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                  end else begin
                    pop  = 1'b1;
                    pc_d = stack_top;
                  end
                end
                SUB_AND: acc_d = acc_q & b_q;
                SUB_OR:  acc_d = acc_q | b_q;
                SUB_XOR: acc_d = acc_q ^ b_q;
                SUB_NOT: acc_d = ~acc_q;
                SUB_INC: {carry_d, acc_d} = {1'b0, acc_q} + (DW + 1)'(1);
                SUB_INP: acc_d = i;
                SUB_OUT: out_d = acc_q;
                SUB_HLT: state_d = ST_HALT;
                default: ;
              endcase
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Architectural registers: clr wins, otherwise take the computed next values
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_sap3_core.sv
// Directed bench for sap3_core: three instances (default, two-entry stack,
// 16-bit data) loaded through the prog port with hand-assembled programs.
module tb_sap3_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: default parameters
  logic        clr0 = 1'b1, prog0 = 1'b0;
  logic [7:0]  a0 = '0;
  logic [11:0] d0 = '0, i0 = '0;
  logic [11:0] out0;
  logic        halted0, err0;

  // Instance 1: two-entry return stack
  logic        clr1 = 1'b1, prog1 = 1'b0;
  logic [7:0]  a1 = '0;
  logic [11:0] d1 = '0, i1 = '0;
  logic [11:0] out1;
  logic        halted1, err1;

  // Instance 2: 16-bit data path
  logic        clr2 = 1'b1, prog2 = 1'b0;
  logic [7:0]  a2 = '0;
  logic [15:0] d2 = '0, i2 = '0;
  logic [15:0] out2;
  logic        halted2, err2;

  sap3_core #(.DW(12), .AW(8), .STACK_DEPTH(4)) u0 (
    .clk(clk), .clr(clr0), .prog(prog0), .a(a0), .d(d0), .i(i0),
    .out(out0), .halted(halted0), .err(err0)
  );

  sap3_core #(.DW(12), .AW(8), .STACK_DEPTH(2)) u1 (
    .clk(clk), .clr(clr1), .prog(prog1), .a(a1), .d(d1), .i(i1),
    .out(out1), .halted(halted1), .err(err1)
  );

  sap3_core #(.DW(16), .AW(8), .STACK_DEPTH(4)) u2 (
    .clk(clk), .clr(clr2), .prog(prog2), .a(a2), .d(d2), .i(i2),
    .out(out2), .halted(halted2), .err(err2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic is_halted(input int which);
    case (which)
      0:       return halted0;
      1:       return halted1;
      default: return halted2;
    endcase
  endfunction

  // Hold an instance in reset (loading happens under clr, which is legal)
  task automatic hold_reset(input int which);
    @(negedge clk);
    case (which)
      0:       clr0 = 1'b1;
      1:       clr1 = 1'b1;
      default: clr2 = 1'b1;
    endcase
  endtask

  // Present one word on the programming port; it is written at the next posedge
  task automatic load(input int which, input logic [7:0] addr, input logic [15:0] data);
    @(negedge clk);
    case (which)
      0:       begin prog0 = 1'b1; a0 = addr; d0 = data[11:0]; end
      1:       begin prog1 = 1'b1; a1 = addr; d1 = data[11:0]; end
      default: begin prog2 = 1'b1; a2 = addr; d2 = data;       end
    endcase
  endtask

  // Drop prog, give one reset edge, then release clr on a falling edge
  task automatic release_run(input int which);
    @(negedge clk);
    case (which)
      0:       prog0 = 1'b0;
      1:       prog1 = 1'b0;
      default: prog2 = 1'b0;
    endcase
    @(negedge clk);
    case (which)
      0:       clr0 = 1'b0;
      1:       clr1 = 1'b0;
      default: clr2 = 1'b0;
    endcase
  endtask

  task automatic wait_halt(input int which, input string tag);
    int n;
    n = 0;
    while (!is_halted(which) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(is_halted(which)), 32'd1);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    edges(2);
    check("rst_out", 32'(out0), 32'h000);
    check("rst_halted", 32'(halted0), 32'd0);
    check("rst_err", 32'(err0), 32'd0);
    check("rst_pc", 32'(u0.pc_q), 32'd0);

    // Program 1: INP / LDB / AND / JAZ select between FFF and 000
    i0 = 12'h001;
    load(0, 8'h00, 16'hFD0); load(0, 8'h01, 16'h409); load(0, 8'h02, 16'hF80);
    load(0, 8'h03, 16'h806); load(0, 8'h04, 16'h00A); load(0, 8'h05, 16'h607);
    load(0, 8'h06, 16'h00B); load(0, 8'h07, 16'hFE0); load(0, 8'h08, 16'hFF0);
    load(0, 8'h09, 16'h001); load(0, 8'h0A, 16'hFFF); load(0, 8'h0B, 16'h000);
    release_run(0);
    edges(13);
    check("p1_out_edge13", 32'(out0), 32'h000);
    edges(1);
    check("p1_out_edge14", 32'(out0), 32'hFFF);
    check("p1_not_halted_yet", 32'(halted0), 32'd0);
    wait_halt(0, "p1_halt");
    check("p1_out_final", 32'(out0), 32'hFFF);

    // Same program, i=0: JAZ taken, A loaded from 0B
    hold_reset(0);
    i0 = 12'h000;
    release_run(0);
    wait_halt(0, "p1b_halt");
    check("p1b_out", 32'(out0), 32'h000);
    check("p1b_acc", 32'(u0.acc_q), 32'h000);
    check("p1b_pc", 32'(u0.pc_q), 32'h009);

    // Program 2: LDA FFF; ADD 001 (carry out); JAC t; t: INC; OUT; HLT
    hold_reset(0);
    load(0, 8'h00, 16'h00A); load(0, 8'h01, 16'h10B); load(0, 8'h02, 16'h705);
    load(0, 8'h03, 16'hFE0); load(0, 8'h04, 16'hFF0); load(0, 8'h05, 16'hFC0);
    load(0, 8'h06, 16'hFE0); load(0, 8'h07, 16'hFF0);
    load(0, 8'h0A, 16'hFFF); load(0, 8'h0B, 16'h001);
    release_run(0);
    edges(4);
    check("p2_add_acc", 32'(u0.acc_q), 32'h000);
    check("p2_add_carry", 32'(u0.carry_q), 32'd1);
    wait_halt(0, "p2_halt");
    check("p2_out", 32'(out0), 32'h001);
    check("p2_inc_carry", 32'(u0.carry_q), 32'd0);
    check("p2_err", 32'(err0), 32'd0);

    // clr during EXEC of the ADD, then rerun from intact memory
    hold_reset(0);
    release_run(0);
    edges(3);
    check("clr_pre_acc", 32'(u0.acc_q), 32'hFFF);
    clr0 = 1'b1;
    edges(1);
    check("clr_acc", 32'(u0.acc_q), 32'h000);
    check("clr_carry", 32'(u0.carry_q), 32'd0);
    check("clr_pc", 32'(u0.pc_q), 32'd0);
    clr0 = 1'b0;
    wait_halt(0, "clr_rerun_halt");
    check("clr_rerun_out", 32'(out0), 32'h001);

    // Logic ops: 0F0 | 0CC = 0FC; ^ 0CC = 030; ~ = FCF
    hold_reset(0);
    load(0, 8'h00, 16'h00E); load(0, 8'h01, 16'h40F); load(0, 8'h02, 16'hF90);
    load(0, 8'h03, 16'hFA0); load(0, 8'h04, 16'hFB0); load(0, 8'h05, 16'hFE0);
    load(0, 8'h06, 16'hFF0); load(0, 8'h0E, 16'h0F0); load(0, 8'h0F, 16'h0CC);
    release_run(0);
    wait_halt(0, "logic_halt");
    check("logic_out", 32'(out0), 32'hFCF);

    // CALL a subroutine doing INC; RET; then STA / reload through memory; OUT
    hold_reset(0);
    load(0, 8'h00, 16'h00E); load(0, 8'h01, 16'h508); load(0, 8'h02, 16'h30F);
    load(0, 8'h03, 16'h00D); load(0, 8'h04, 16'h00F); load(0, 8'h05, 16'hFE0);
    load(0, 8'h06, 16'hFF0); load(0, 8'h08, 16'hFC0); load(0, 8'h09, 16'hF00);
    load(0, 8'h0D, 16'h000); load(0, 8'h0E, 16'h123); load(0, 8'h0F, 16'h000);
    release_run(0);
    wait_halt(0, "call_halt");
    check("call_out", 32'(out0), 32'h124);
    check("call_sp", 32'(u0.u_stack.sp_q), 32'd0);
    check("call_err", 32'(err0), 32'd0);

    // RET with an empty stack
    hold_reset(0);
    load(0, 8'h00, 16'hF00);
    release_run(0);
    wait_halt(0, "ret_empty_halt");
    check("ret_empty_err", 32'(err0), 32'd1);
    check("ret_empty_pc", 32'(u0.pc_q), 32'd1);

    // Two-entry stack, three nested CALLs: third one faults at pc=5
    load(1, 8'h00, 16'h502); load(1, 8'h02, 16'h504); load(1, 8'h04, 16'h506);
    load(1, 8'h06, 16'hFF0);
    release_run(1);
    wait_halt(1, "ovf_halt");
    check("ovf_err", 32'(err1), 32'd1);
    check("ovf_pc", 32'(u1.pc_q), 32'd5);
    check("ovf_sp", 32'(u1.u_stack.sp_q), 32'd2);

    // 16-bit: 0005 - 0007 = FFFE with borrow; JAN taken to OUT
    load(2, 8'h00, 16'h0010); load(2, 8'h01, 16'h2011); load(2, 8'h02, 16'h9005);
    load(2, 8'h03, 16'hFF00); load(2, 8'h05, 16'hFE00); load(2, 8'h06, 16'hFF00);
    load(2, 8'h10, 16'h0005); load(2, 8'h11, 16'h0007);
    release_run(2);
    wait_halt(2, "w16_halt");
    check("w16_out", 32'(out2), 32'hFFFE);
    check("w16_carry", 32'(u2.carry_q), 32'd1);
    check("w16_err", 32'(err2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
